// File: rtl/dwt97_pkg.sv
// Shared definitions for the DWT 9/7 stage, its quantizer and their benches.
// Contents:
//   band_t          subband code {y[0],x[0]}: LL, HL, LH, HH
//   DWT_DATA_WIDTH  default coefficient width
//   DWT_POINT       default fractional bits of a coefficient
//   DWT_SIDE_SIZE   default tile side length
package dwt97_pkg;

  typedef enum logic [1:0] {
    LL = 2'b00,
    HL = 2'b01,
    LH = 2'b10,
    HH = 2'b11
  } band_t;

  localparam int unsigned DWT_DATA_WIDTH = 16;
  localparam int unsigned DWT_POINT      = 10;
  localparam int unsigned DWT_SIDE_SIZE  = 16;

endpackage

// File: rtl/dwt97_tile_pos.sv
// Tile position tracker. Holds the x/y raster position of the next beat,
// gives its subband and whether it opens a tile, and checks the tile framing.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   step       an input beat is accepted this cycle
//   last       in_last of the accepted beat
//   band       subband {y[0],x[0]} of the current position
//   first      current position is x=0, y=0
//   err_last   sticky: in_last early or missing
module dwt97_tile_pos
  import dwt97_pkg::*;
#(
  parameter int unsigned SideSize = DWT_SIDE_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       last,
  output logic [1:0] band,
  output logic       first,
  output logic       err_last
);

  localparam int unsigned CW = $clog2(SideSize);
  localparam logic [CW-1:0] PosMax = CW'(SideSize - 1);

  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          at_end;

  assign at_end = (x == PosMax) && (y == PosMax);
  assign band   = {y[0], x[0]};
  assign first  = (x == '0) && (y == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      err_last <= 1'b0;
    end else if (step) begin
      if (last && !at_end) begin
        // Early end of tile: resynchronise so the next beat starts a tile.
        err_last <= 1'b1;
        x        <= '0;
        y        <= '0;
      end else begin
        if (!last && at_end) begin
          err_last <= 1'b1;
        end
        if (x == PosMax) begin
          x <= '0;
          y <= (y == PosMax) ? '0 : y + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dwt97_quantizer.sv
// Per-subband dead-zone scalar quantizer for 2D DWT 9/7 coefficients.
// Three-stage pipeline with a global stall: |coef| and step select, multiply
// by the reciprocal step, shift/saturate to a sign-magnitude index.
// Optional macro DWT97_QUANT_ROUND_EN: round half up before the shift
// instead of truncating.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   inv_step              reciprocal steps {HH,LH,HL,LL}, Q2.14 each
//   in_data/valid/last    coefficient stream, in_ready back-pressure
//   out_sign/mag/band     quantized index and its subband
//   out_last/valid        end-of-tile marker and valid, out_ready back-pressure
//   err_last              sticky tile-framing error
module dwt97_quantizer
  import dwt97_pkg::*;
#(
  parameter int unsigned DataWidth = DWT_DATA_WIDTH,
  parameter int unsigned Point     = DWT_POINT,
  parameter int unsigned SideSize  = DWT_SIDE_SIZE,
  parameter int unsigned InvWidth  = 16,
  parameter int unsigned InvFrac   = 14,
  parameter int unsigned MagWidth  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*InvWidth-1:0] inv_step,
  input  logic [DataWidth-1:0]  in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_sign,
  output logic [MagWidth-1:0]   out_mag,
  output logic [1:0]            out_band,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_last
);

  localparam int unsigned ProdW  = DataWidth + InvWidth;
  localparam int unsigned Shift  = Point + InvFrac;
`ifdef DWT97_QUANT_ROUND_EN
  localparam int unsigned SumW   = ProdW + 1;
`else
  localparam int unsigned SumW   = ProdW;
`endif
  localparam int unsigned QW     = SumW - Shift;
  localparam int unsigned MagMax = (1 << MagWidth) - 1;

  logic advance;
  logic hs;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign hs       = in_valid && advance;

  logic [1:0] pos_band;
  logic       pos_first;

  dwt97_tile_pos #(
    .SideSize(SideSize)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .step    (hs),
    .last    (in_last),
    .band    (pos_band),
    .first   (pos_first),
    .err_last(err_last)
  );

  // Step set latched at the first beat of a tile. That first beat must see
  // the incoming set already, so selection bypasses the latch on x=y=0.
  logic [4*InvWidth-1:0] inv_lat;
  logic [4*InvWidth-1:0] inv_set;
  logic [InvWidth-1:0]   inv_sel;
  logic [DataWidth-1:0]  mag_c;

  always_comb begin
    inv_set = pos_first ? inv_step : inv_lat;
    inv_sel = inv_set[InvWidth-1:0];
    case (band_t'(pos_band))
      LL:      inv_sel = inv_set[InvWidth-1:0];
      HL:      inv_sel = inv_set[2*InvWidth-1:InvWidth];
      LH:      inv_sel = inv_set[3*InvWidth-1:2*InvWidth];
      HH:      inv_sel = inv_set[4*InvWidth-1:3*InvWidth];
      default: inv_sel = inv_set[InvWidth-1:0];
    endcase
    // Unsigned view of the negation keeps the most negative value exact.
    mag_c = in_data[DataWidth-1] ? (~in_data) + DataWidth'(1) : in_data;
  end

  logic                 s1_valid, s1_sign, s1_last;
  logic [DataWidth-1:0] s1_mag;
  logic [InvWidth-1:0]  s1_inv;
  band_t                s1_band;

  logic                 s2_valid, s2_sign, s2_last;
  logic [ProdW-1:0]     s2_prod;
  band_t                s2_band;

  logic [ProdW-1:0]     prod_c;
  logic [SumW-1:0]      sum;
  logic [QW-1:0]        q;
  logic [MagWidth-1:0]  q_mag;
  logic                 q_sign;

  assign prod_c = ProdW'(s1_mag) * ProdW'(s1_inv);

  always_comb begin
    sum = SumW'(s2_prod);
`ifdef DWT97_QUANT_ROUND_EN
    sum = sum + (SumW'(1) << (Shift - 1));
`endif
    q      = QW'(sum >> Shift);
    q_mag  = (q > QW'(MagMax)) ? '1 : q[MagWidth-1:0];
    q_sign = s2_sign && (q_mag != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_lat   <= '0;
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_last   <= 1'b0;
      s1_mag    <= '0;
      s1_inv    <= '0;
      s1_band   <= LL;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_last   <= 1'b0;
      s2_prod   <= '0;
      s2_band   <= LL;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      out_band  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (hs && pos_first) begin
        inv_lat <= inv_step;
      end
      if (advance) begin
        s1_valid  <= in_valid;
        s1_sign   <= in_data[DataWidth-1];
        s1_last   <= in_last;
        s1_mag    <= mag_c;
        s1_inv    <= inv_sel;
        s1_band   <= band_t'(pos_band);
        s2_valid  <= s1_valid;
        s2_sign   <= s1_sign;
        s2_last   <= s1_last;
        s2_prod   <= prod_c;
        s2_band   <= s1_band;
        out_valid <= s2_valid;
        out_sign  <= q_sign;
        out_mag   <= q_mag;
        out_band  <= s2_band;
        out_last  <= s2_last;
      end
    end
  end

endmodule

// File: tb/tb_dwt97_quantizer.sv
// Self-checking bench for dwt97_quantizer: table of single-coefficient
// vectors plus directed sequences for latency, a full tile under random
// back-pressure, framing errors, stall stability and mid-tile reset.
module tb_dwt97_quantizer;
  import dwt97_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] inv_step = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        out_sign;
  logic [5:0]  out_mag;
  logic [1:0]  out_band;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        err_last;

  dwt97_quantizer dut (
    .clk      (clk),
    .rst      (rst),
    .inv_step (inv_step),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_sign (out_sign),
    .out_mag  (out_mag),
    .out_band (out_band),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_last (err_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       sign;
    logic [5:0] mag;
    logic [1:0] band;
    logic       last;
  } obeat_t;

  obeat_t oq[$];

  logic rand_en = 1'b0;
  logic ready_fix = 1'b1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      oq.push_back({out_sign, out_mag, out_band, out_last});
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference quantizer, written from the arithmetic definition.
  function automatic obeat_t model(input logic [15:0] d, input logic [15:0] st,
                                   input logic [1:0] b, input logic l);
    logic [15:0] m;
    logic [32:0] p;
    logic [32:0] qq;
    obeat_t r;
    m = d[15] ? 16'(-d) : d;
    p = 33'(m) * 33'(st);
`ifdef DWT97_QUANT_ROUND_EN
    p = p + (33'd1 << 23);
`endif
    qq = p >> 24;
    r.mag  = (qq > 33'd63) ? 6'd63 : qq[5:0];
    r.sign = d[15] && (r.mag != 6'd0);
    r.band = b;
    r.last = l;
    return r;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    oq.delete();
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int unsigned n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accepted");
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int unsigned n);
    int unsigned c = 0;
    while (oq.size() < n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [63:0] steps;
    int unsigned skip;
    logic        sign;
    logic [5:0]  mag;
    logic [1:0]  band;
  } vec_t;

`ifdef DWT97_QUANT_ROUND_EN
  localparam logic [5:0] MAG_575 = 6'd3;
`else
  localparam logic [5:0] MAG_575 = 6'd2;
`endif

  vec_t        vecs[9];
  logic [15:0] tdata[256];
  logic [63:0] saved;
  obeat_t      ob;
  obeat_t      exp_b;
  int unsigned lat;
  int unsigned nlast;
  logic [7:0]  idx;
  logic [5:0]  held_mag;

  initial begin
    vecs[0] = '{16'h0400, {4{16'd16384}}, 0, 1'b0, 6'd1, LL};
    vecs[1] = '{16'hF400, {16'd16384, 16'd16384, 16'd16384, 16'd8192}, 1, 1'b1, 6'd3, HL};
    vecs[2] = '{16'd5888, {4{16'd8192}}, 0, 1'b0, MAG_575, LL};
    vecs[3] = '{16'h8000, {4{16'hFFFF}}, 0, 1'b1, 6'd63, LL};
    vecs[4] = '{16'hFFFF, {4{16'd16384}}, 0, 1'b0, 6'd0, LL};
    vecs[5] = '{16'h0800, {16'd32768, 16'd16384, 16'd16384, 16'd16384}, 17, 1'b0, 6'd4, HH};
    vecs[6] = '{16'hF000, {16'd16384, 16'd4096, 16'd16384, 16'd16384}, 16, 1'b1, 6'd1, LH};
    vecs[7] = '{16'h7FFF, {4{16'hFFFF}}, 0, 1'b0, 6'd63, LL};
    vecs[8] = '{16'd32256, {4{16'd32768}}, 0, 1'b0, 6'd63, LL};

    // Reset values and first-beat latency.
    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sign", 32'(out_sign), 32'd0);
    check("rst_out_mag", 32'(out_mag), 32'd0);
    check("rst_out_band", 32'(out_band), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_err_last", 32'(err_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    inv_step = {4{16'd16384}};
    @(posedge clk);
    #1;
    send(16'h0400, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", lat, 32'd3);
    check("lat_mag", 32'(out_mag), 32'd1);

    // Table-driven single coefficients at chosen positions.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      inv_step = vecs[i].steps;
      for (int k = 0; k < int'(vecs[i].skip); k++) send(16'h0000, 1'b0);
      send(vecs[i].data, 1'b0);
      wait_out(vecs[i].skip + 1);
      check($sformatf("v%0d_count", i), oq.size(), vecs[i].skip + 1);
      if (oq.size() > vecs[i].skip) begin
        ob = oq[vecs[i].skip];
        check($sformatf("v%0d_sign", i), 32'(ob.sign), 32'(vecs[i].sign));
        check($sformatf("v%0d_mag", i), 32'(ob.mag), 32'(vecs[i].mag));
        check($sformatf("v%0d_band", i), 32'(ob.band), 32'(vecs[i].band));
      end
    end

    // Full tile, random back-pressure, step set changed after the first beat.
    do_reset();
    inv_step = {16'd12000, 16'd20000, 16'd30000, 16'd16384};
    saved = inv_step;
    rand_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tdata[i] = 16'($urandom);
      send(tdata[i], i == 255);
      if (i == 0) inv_step = 64'h1111_2222_3333_4444;
    end
    wait_out(256);
    rand_en = 1'b0;
    check("tile_count", oq.size(), 32'd256);
    check("tile_err_last", 32'(err_last), 32'd0);
    if (oq.size() >= 256) begin
      for (int i = 0; i < 256; i++) begin
        idx = 8'(i);
        exp_b = model(tdata[i], saved[{idx[4], idx[0]} * 16 +: 16], {idx[4], idx[0]}, i == 255);
        check($sformatf("tile_beat%0d", i), 32'(oq[i]), 32'(exp_b));
      end
    end

    // Early in_last on beat 100.
    do_reset();
    inv_step = {4{16'd16384}};
    for (int i = 0; i <= 100; i++) begin
      send(16'h0400, i == 100);
      if (i == 99) check("early_err_before", 32'(err_last), 32'd0);
    end
    check("early_err_after", 32'(err_last), 32'd1);
    send(16'h0400, 1'b0);
    wait_out(102);
    check("early_count", oq.size(), 32'd102);
    if (oq.size() >= 102) begin
      check("early_b99_band", 32'(oq[99].band), 32'(HL));
      check("early_b100_last", 32'(oq[100].last), 32'd1);
      check("early_next_band", 32'(oq[101].band), 32'(LL));
    end
    check("early_err_sticky", 32'(err_last), 32'd1);

    // in_last missing at the end of a tile.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(16'h0400, 1'b0);
      if (i == 254) check("miss_err_before", 32'(err_last), 32'd0);
    end
    check("miss_err_after", 32'(err_last), 32'd1);
    send(16'h0C00, 1'b0);
    wait_out(257);
    check("miss_count", oq.size(), 32'd257);
    nlast = 0;
    foreach (oq[i]) if (oq[i].last) nlast++;
    check("miss_no_last", nlast, 32'd0);
    if (oq.size() >= 257) begin
      check("miss_wrap_band", 32'(oq[256].band), 32'(LL));
      check("miss_wrap_mag", 32'(oq[256].mag), 32'd3);
    end

    // Stall stability, then reset with a full pipeline.
    do_reset();
    for (int i = 0; i < 4; i++) send(16'h0400, i == 3);
    wait_out(4);
    check("stall_err_set", 32'(err_last), 32'd1);
    ready_fix = 1'b0;
    @(posedge clk);
    #2;
    send(16'h0400, 1'b0);
    send(16'h0800, 1'b0);
    send(16'h0C00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_valid", 32'(out_valid), 32'd1);
    held_mag = out_mag;
    check("stall_head_mag", 32'(held_mag), 32'd1);
    repeat (2) @(negedge clk);
    check("stall_hold_mag", 32'(out_mag), 32'(held_mag));
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_err", 32'(err_last), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    oq.delete();
    ready_fix = 1'b1;
    inv_step = {4{16'd32768}};
    @(posedge clk);
    #2;
    send(16'h0400, 1'b0);
    send(16'h0400, 1'b0);
    send(16'h0400, 1'b0);
    wait_out(3);
    check("midrst_count", oq.size(), 32'd3);
    if (oq.size() >= 3) begin
      check("midrst_b0_band", 32'(oq[0].band), 32'(LL));
      check("midrst_b1_band", 32'(oq[1].band), 32'(HL));
      check("midrst_b0_mag", 32'(oq[0].mag), 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dwt97_quantizer.md
Name: dwt97_quantizer

Overview:
- Downstream neighbour of the 2D DWT 9/7 stage; consumes its wavelet coefficients.
- Input: one 16x16 tile of signed fixed-point coefficients, streamed in interleaved raster order.
- Tracks x/y position to classify each coefficient into LL/HL/LH/HH.
- Applies a per-subband dead-zone scalar quantizer (multiply by reciprocal step, truncate).
- Output: sign-magnitude indices for the entropy-coding stage.

Parameters:
- DataWidth, 16, coefficient width, two's complement.
- Point, 10, fractional bits of the input coefficient.
- SideSize, 16, tile side; power of two, at least 2.
- InvWidth, 16, width of each reciprocal step, unsigned.
- InvFrac, 14, fractional bits of the reciprocal step (Q2.14).
- MagWidth, 6, output magnitude width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inv_step  in  4*InvWidth  reciprocal steps; [15:0]=LL, [31:16]=HL, [47:32]=LH, [63:48]=HH
- in_data  in  DataWidth  coefficient, signed, Q(DataWidth-Point).Point
- in_valid  in  1  input beat valid
- in_last  in  1  asserted with the final beat of a tile
- in_ready  out  1  block accepts a beat this cycle
- out_sign  out  1  1 = negative coefficient
- out_mag  out  MagWidth  quantized magnitude
- out_band  out  2  subband {y[0],x[0]}: 00 LL, 01 HL, 10 LH, 11 HH
- out_last  out  1  final index of the tile
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- err_last  out  1  sticky tile-framing error flag

Behaviour:
- Clock and reset:
  - Single clock clk. rst is synchronous and active-high.
  - Reset clears all stage valids, x/y counters, the latched step set and err_last.
  - Reset values: out_valid=0, out_sign=0, out_mag=0, out_band=0, out_last=0, err_last=0.
  - in_ready=1 in the first cycle after reset is released.
  - rst asserted mid-tile discards all in-flight beats; the next accepted beat is treated as x=0, y=0.
- Handshake and stall:
  - Beat transfers when valid && ready on either side.
  - Global stall pipeline: advance = !out_valid || out_ready; in_ready = advance.
  - Data and valid of every stage hold while stalled.
  - out_* stable while out_valid && !out_ready.
- Latency:
  - 3 cycles from the input handshake to out_valid with no stall; throughput 1 beat/cycle.
- Pipeline stages:
  - S1: band = {y[0],x[0]}; sign = in_data MSB; mag = |in_data| in DataWidth bits unsigned (-2^(DataWidth-1) gives 2^(DataWidth-1), no overflow); select the reciprocal from the latched set.
  - S2: product = mag * inv, DataWidth+InvWidth bits unsigned.
  - S3: q = product >> (Point+InvFrac). Saturate to 2^MagWidth-1 if q exceeds it. If q==0, force out_sign=0.
- Step latching:
  - inv_step is sampled on the handshake of the first beat of each tile (x=0, y=0).
  - That set is used for the whole tile; changes mid-tile are ignored.
- Position counters:
  - x increments on each input handshake; wraps at SideSize-1 and increments y.
  - y wraps at SideSize-1, returning both counters to 0.
- Framing:
  - Expected last position is x=y=SideSize-1.
  - in_last early: set err_last; reset counters to 0 after that beat.
  - in_last missing at the expected position: set err_last; counters wrap normally.
  - out_last follows in_last through the pipeline, not the counter.
  - err_last clears only on rst.

Optional Feature:
- Macro: DWT97_QUANT_ROUND_EN.
- Defined: S3 adds 2^(Point+InvFrac-1) to the product before the shift (round half up on the magnitude), then saturates. The product width grows by 1 bit.
- Undefined: plain truncation (dead-zone quantizer); no adder present.
- Latency is 3 in both builds.

Decomposition:
- Package dwt97_pkg holds:
  - band_t enum: LL=2'b00, HL=2'b01, LH=2'b10, HH=2'b11.
  - Default DataWidth, Point and SideSize constants, shared with the DWT stage and its bench.
- One natural sub-module: dwt97_tile_pos, the x/y counters with last checking and band output. The quantizer datapath stays in the top level.

Test Plan:
- All steps 16384 (1.0); in_data 1024 (1.0) at x=0,y=0 -> out_sign=0, out_mag=1, out_band=LL, 3 cycles after the handshake.
- in_data 0xF400 (-3.0) at x=1,y=0, HL step 16384 -> out_sign=1, out_mag=3, out_band=HL.
- in_data 5888 (5.75), step 8192 (0.5) -> out_mag=2; out_mag=3 with DWT97_QUANT_ROUND_EN.
- in_data 0x8000, step 65535, MagWidth=6 -> out_mag=63 (saturated), out_sign=1. in_data 0xFFFF, step 16384 -> out_mag=0, out_sign=0.
- Full 256-beat tile with random out_ready (50% duty) -> 256 outputs in order, matching a golden model. Band pattern repeats 00,01 on even rows and 10,11 on odd rows. out_last only on beat 255; no beat lost or duplicated.
- in_last on beat 100 -> err_last=1 from that beat on; the next beat is out_band=LL (x=0,y=0). rst mid-tile -> out_valid=0 the next cycle, err_last=0.
